// File: rtl/rr_arb_4_1_if.sv
// Handshake bundle for the 4:1 round-robin arbiter: four request channels in, one registered word out.
// The arbiter takes the slave modport; the producer/consumer side takes master.
interface rr_arb_4_1_if #(
  parameter int unsigned W = 4
) ();

  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  modport master (
    output in_valid,
    output d0,
    output d1,
    output d2,
    output d3,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  d0,
    input  d1,
    input  d2,
    input  d3,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

endinterface

// File: rtl/rr_arb_4_1.sv
// Four-channel round-robin arbiter with a one-slot registered output (winning data plus select index).
// Define RR_ARB_4_1_FIXED_PRIO_EN for strict fixed priority (channel 0 highest) instead of round-robin.
module rr_arb_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_arb_4_1_if.slave   bus
);

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   sel_q, sel_d;

  logic         load;
  logic         found;
  logic         xfer;
  logic [1:0]   start;
  logic [1:0]   idx;
  logic [1:0]   win;
  logic [W-1:0] win_data;

`ifdef RR_ARB_4_1_FIXED_PRIO_EN
  assign start = 2'd0;
`else
  logic [1:0] last_q, last_d;

  // Search begins just past the previous winner; 2-bit wrap gives the mod-4.
  assign start = last_q + 2'd1;
`endif

  // Output slot can take a word when empty or when it is drained on this edge.
  assign load = (state_q == StEmpty) || bus.out_ready;

  always_comb begin
    found = 1'b0;
    win   = start;
    idx   = 2'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = start + k[1:0];
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reset blocks every grant so nothing transfers on the reset edge.
  assign xfer         = found && load && !rst;
  assign bus.in_ready = xfer ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    win_data = bus.d0;
    case (win)
      2'd0:    win_data = bus.d0;
      2'd1:    win_data = bus.d1;
      2'd2:    win_data = bus.d2;
      default: win_data = bus.d3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
`ifndef RR_ARB_4_1_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StEmpty: begin
        if (xfer) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (xfer) begin
          state_d = StFull;
        end else if (bus.out_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (xfer) begin
      data_d = win_data;
      sel_d  = win;
`ifndef RR_ARB_4_1_FIXED_PRIO_EN
      last_d = win;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= 2'd0;
`ifndef RR_ARB_4_1_FIXED_PRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
`ifndef RR_ARB_4_1_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Self-checking bench for rr_arb_4_1: scenario tasks plus a negedge scoreboard of granted words.
module tb_rr_arb_4_1;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rr_arb_4_1_if #(.W(W)) bus ();

  rr_arb_4_1 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, advanced once per cycle on the falling edge.
  exp_t       sb_q[$];
  logic       m_full = 1'b0;
  logic [1:0] m_last = 2'd3;

  function automatic logic [W-1:0] pick(input logic [1:0] s);
    case (s)
      2'd0:    return bus.d0;
      2'd1:    return bus.d1;
      2'd2:    return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [1:0] m_start;
    logic [1:0] m_idx;
    logic [1:0] m_win;
    logic       m_found;
    logic       m_load;
    logic [3:0] m_ready;
    exp_t       e;
    checks++;
    if (bus.out_valid !== m_full) begin
      errors++;
      $display("FAIL sb_out_valid: got %b want %b at %0t", bus.out_valid, m_full, $time);
    end
    if (m_full) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got empty queue want a word at %0t", $time);
      end else if (bus.out_data !== sb_q[0].data || bus.out_sel !== sb_q[0].sel) begin
        errors++;
        $display("FAIL sb_word: got data=%h sel=%0d want data=%h sel=%0d at %0t",
                 bus.out_data, bus.out_sel, sb_q[0].data, sb_q[0].sel, $time);
      end
    end
    if (rst) begin
      checks++;
      if (bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL sb_rst_in_ready: got %b want 0000 at %0t", bus.in_ready, $time);
      end
      sb_q.delete();
      m_full = 1'b0;
      m_last = 2'd3;
    end else begin
`ifdef RR_ARB_4_1_FIXED_PRIO_EN
      m_start = 2'd0;
`else
      m_start = m_last + 2'd1;
`endif
      m_found = 1'b0;
      m_win   = 2'd0;
      for (int k = 0; k < 4; k++) begin
        m_idx = m_start + 2'(k);
        if (!m_found && bus.in_valid[m_idx]) begin
          m_found = 1'b1;
          m_win   = m_idx;
        end
      end
      m_load  = !m_full || bus.out_ready;
      m_ready = (m_found && m_load) ? (4'b0001 << m_win) : 4'b0000;
      checks++;
      if (bus.in_ready !== m_ready) begin
        errors++;
        $display("FAIL sb_in_ready: got %b want %b at %0t", bus.in_ready, m_ready, $time);
      end
      if (m_full && bus.out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (m_found && m_load) begin
        e.data = pick(m_win);
        e.sel  = m_win;
        sb_q.push_back(e);
        m_last = m_win;
        m_full = 1'b1;
      end else if (bus.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sel !== 2'd0
        || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h sel=%0d rdy=%b want 0 0 0 0000",
               bus.out_valid, bus.out_data, bus.out_sel, bus.in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_sel [5];
    logic [W-1:0] exp_dat [5];
`ifdef RR_ARB_4_1_FIXED_PRIO_EN
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_dat = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
`else
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
`endif
    bus.d0 = 4'd1; bus.d1 = 4'd2; bus.d2 = 4'd3; bus.d3 = 4'd4;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[i] || bus.out_data !== exp_dat[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got valid=%b sel=%0d data=%h want 1 %0d %h", i,
                 bus.out_valid, bus.out_sel, bus.out_data, exp_sel[i], exp_dat[i]);
      end
    end
    bus.in_valid = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bus.d2       = 4'hA;
    bus.in_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_in_ready: got %b want 0100", bus.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.out_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out: got valid=%b data=%h sel=%0d want 1 a 2",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    bus.in_valid = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.d0        = 4'd5;
    bus.in_valid  = 4'b0001;
    @(posedge clk);
    #1;
    bus.d1       = 4'd6;
    bus.d3       = 4'd7;
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== 4'd5
          || bus.out_sel !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b valid=%b data=%h sel=%0d want 0000 1 5 0", i,
                 bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
      end
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_rdy: got %b want 0010", bus.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd6 || bus.out_sel !== 2'd1) begin
      errors++;
      $display("FAIL bp_release_out: got valid=%b data=%h sel=%0d want 1 6 1",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    bus.in_valid = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.d2        = 4'd9;
    bus.in_valid  = 4'b0100;
    @(posedge clk);
    #1;
    bus.d0       = 4'd3;
    bus.in_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0001 || bus.out_valid !== 1'b1 || bus.out_data !== 4'd9) begin
      errors++;
      $display("FAIL b2b_full: got rdy=%b valid=%b data=%h want 0001 1 9",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd3 || bus.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL b2b_refill: got valid=%b data=%h sel=%0d want 1 3 0",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    bus.in_valid = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.d0 = 4'd1; bus.d1 = 4'd2; bus.d2 = 4'd3; bus.d3 = 4'd4;
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid: got valid=%b rdy=%b want 0 0000", bus.out_valid, bus.in_ready);
    end
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0110;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_mid_first_grant: got %b want 0010", bus.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 4'd2) begin
      errors++;
      $display("FAIL rst_mid_out: got valid=%b sel=%0d data=%h want 1 1 2",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
    bus.in_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    bus.d0        = '0;
    bus.d1        = '0;
    bus.d2        = '0;
    bus.d3        = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
